// File: rtl/svm_pkg.sv
// Shared types and constants for the SVM decision-accumulation stage.
package svm_pkg;

  // Decision FSM state encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    BIAS  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Width of the accepted-result counter.
  localparam int SV_CNT_W = 7;

  // Smallest accumulator width that holds NUM_OF_SV kernel results plus the
  // bias without overflow: result width, growth for the sum, one bit for bias.
  function automatic int acc_w_min(input int xlen_pixel, input int num_of_sv);
    return 2 * xlen_pixel + $clog2(num_of_sv) + 1;
  endfunction

  localparam int XLEN_PIXEL_DEF = 8;
  localparam int NUM_OF_SV_DEF  = 87;
  localparam int ACC_W_DEF      = acc_w_min(XLEN_PIXEL_DEF, NUM_OF_SV_DEF);

endpackage

// File: rtl/svm_decision_accum_if.sv
// Handshake and data bundle between the kernel/controller side and the
// decision accumulator.
interface svm_decision_accum_if #(
  parameter int XLEN_PIXEL = svm_pkg::XLEN_PIXEL_DEF,
  parameter int ACC_W      = svm_pkg::ACC_W_DEF
) ();
  import svm_pkg::*;

  logic                           stall_MEM;
  logic                           start;
  logic                           hwf_valid;
  logic signed [2*XLEN_PIXEL-1:0] hwf_out;
  logic signed [2*XLEN_PIXEL-1:0] bias;
  logic                           result_ready;
  logic                           busy;
  logic                           result_valid;
  logic signed [ACC_W-1:0]        score;
  logic                           decision;
  logic [SV_CNT_W-1:0]            sv_cnt;

  // Controller / kernel side.
  modport master (
    output stall_MEM, start, hwf_valid, hwf_out, bias, result_ready,
    input  busy, result_valid, score, decision, sv_cnt
  );

  // Accumulator side.
  modport slave (
    input  stall_MEM, start, hwf_valid, hwf_out, bias, result_ready,
    output busy, result_valid, score, decision, sv_cnt
  );

endinterface

// File: rtl/svm_acc_reg.sv
// Sign-extending, clearable, enable-gated signed accumulator. The running sum
// (acc + extended operand) is also exported so the caller can capture the
// final value on the same edge it is written back.
module svm_acc_reg #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [IN_W-1:0]  operand,
  output logic signed [ACC_W-1:0] acc,
  output logic signed [ACC_W-1:0] sum
);

  logic signed [ACC_W-1:0] acc_reg;
  logic signed [ACC_W-1:0] operand_ext;

  // Sign-extend the operand and form the full-width sum.
  always_comb begin
    operand_ext = {{(ACC_W-IN_W){operand[IN_W-1]}}, operand};
    sum         = acc_reg + operand_ext;
  end

  // Accumulator register: clear has priority over accumulate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg <= '0;
    end else if (clr) begin
      acc_reg <= '0;
    end else if (en) begin
      acc_reg <= sum;
    end
  end

  assign acc = acc_reg;

endmodule

// File: rtl/svm_decision_accum.sv
// Accumulates NUM_OF_SV weighted kernel results, adds the stage bias and
// hands the signed score plus class decision to the cascade controller.
module svm_decision_accum
  import svm_pkg::*;
#(
  parameter int XLEN_PIXEL = XLEN_PIXEL_DEF,
  parameter int NUM_OF_SV  = NUM_OF_SV_DEF,
  parameter int ACC_W      = ACC_W_DEF
) (
  input logic                 clk,
  input logic                 rst,
  svm_decision_accum_if.slave bus
);

  localparam int IN_W = 2 * XLEN_PIXEL;
  localparam logic [SV_CNT_W-1:0] LAST_SV = SV_CNT_W'(NUM_OF_SV - 1);

  state_t                  state_reg, state_next;
  logic [SV_CNT_W-1:0]     sv_cnt_reg;
  logic signed [ACC_W-1:0] score_reg;
  logic                    decision_reg;

  logic                    acc_clr, acc_en, sel_bias;
  logic                    cnt_clr, cnt_inc, load_result;
  logic signed [IN_W-1:0]  acc_operand;
  logic signed [ACC_W-1:0] acc_value;
  logic signed [ACC_W-1:0] acc_sum;

  // One adder serves both phases: kernel results in ACCUM, bias in BIAS.
  assign acc_operand = sel_bias ? bus.bias : bus.hwf_out;

  svm_acc_reg #(
    .IN_W  (IN_W),
    .ACC_W (ACC_W)
  ) u_acc (
    .clk     (clk),
    .rst     (rst),
    .clr     (acc_clr),
    .en      (acc_en),
    .operand (acc_operand),
    .acc     (acc_value),
    .sum     (acc_sum)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and datapath controls; a stall freezes everything.
  always_comb begin
    state_next  = state_reg;
    acc_clr     = 1'b0;
    acc_en      = 1'b0;
    sel_bias    = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    load_result = 1'b0;
    if (!bus.stall_MEM) begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            state_next = ACCUM;
            acc_clr    = 1'b1;
            cnt_clr    = 1'b1;
          end
        end
        ACCUM: begin
          if (bus.hwf_valid) begin
            acc_en  = 1'b1;
            cnt_inc = 1'b1;
            if (sv_cnt_reg == LAST_SV) begin
              state_next = BIAS;
            end
          end
        end
        BIAS: begin
          acc_en      = 1'b1;
          sel_bias    = 1'b1;
          load_result = 1'b1;
          state_next  = DONE;
        end
        DONE: begin
          if (bus.result_ready) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Accepted-result counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sv_cnt_reg <= '0;
    end else if (cnt_clr) begin
      sv_cnt_reg <= '0;
    end else if (cnt_inc) begin
      sv_cnt_reg <= sv_cnt_reg + 1'b1;
    end
  end

  // Capture score and decision from the bias addition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score_reg    <= '0;
      decision_reg <= 1'b0;
    end else if (load_result) begin
      score_reg    <= acc_sum;
      decision_reg <= ~acc_sum[ACC_W-1];
    end
  end

  assign bus.busy         = (state_reg == ACCUM) || (state_reg == BIAS);
  assign bus.result_valid = (state_reg == DONE);
  assign bus.score        = score_reg;
  assign bus.decision     = decision_reg;
  assign bus.sv_cnt       = sv_cnt_reg;

endmodule

// File: tb/tb_svm_decision_accum.sv
// Scoreboard bench: a 4-SV instance for short directed decisions and a
// default 87-SV instance for the full-range, stall and reset cases.
module tb_svm_decision_accum;
  import svm_pkg::*;

  typedef struct {
    logic signed [23:0] score;
    logic               dec;
  } exp_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t q4[$];
  exp_t q87[$];

  svm_decision_accum_if #(.XLEN_PIXEL(8), .ACC_W(24)) if4 ();
  svm_decision_accum_if #(.XLEN_PIXEL(8), .ACC_W(24)) if87 ();

  svm_decision_accum #(.XLEN_PIXEL(8), .NUM_OF_SV(4), .ACC_W(24)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4.slave)
  );

  svm_decision_accum #(.XLEN_PIXEL(8), .NUM_OF_SV(87), .ACC_W(24)) dut87 (
    .clk (clk),
    .rst (rst),
    .bus (if87.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Monitors: pop and compare whenever a result is handed over.
  always @(negedge clk) begin
    if (!rst && if4.result_valid && if4.result_ready && !if4.stall_MEM) begin
      checks++;
      if (q4.size() == 0) begin
        errors++;
        $display("FAIL sb4_unexpected: got score %0d with no expected entry", if4.score);
      end else begin
        exp_t e;
        e = q4.pop_front();
        if (if4.score !== e.score || if4.decision !== e.dec) begin
          errors++;
          $display("FAIL sb4: got score %0d dec %0b expected score %0d dec %0b",
                   if4.score, if4.decision, e.score, e.dec);
        end else begin
          $display("sb4  score %0d dec %0b", if4.score, if4.decision);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && if87.result_valid && if87.result_ready && !if87.stall_MEM) begin
      checks++;
      if (q87.size() == 0) begin
        errors++;
        $display("FAIL sb87_unexpected: got score %0d with no expected entry", if87.score);
      end else begin
        exp_t e;
        e = q87.pop_front();
        if (if87.score !== e.score || if87.decision !== e.dec) begin
          errors++;
          $display("FAIL sb87: got score %0d dec %0b expected score %0d dec %0b",
                   if87.score, if87.decision, e.score, e.dec);
        end else begin
          $display("sb87 score %0d dec %0b", if87.score, if87.decision);
        end
      end
    end
  end

  // 4-SV decision; hold > 0 keeps result_ready low that many cycles in DONE
  // and pulses start during the hold.
  task automatic run4(input string tag, input int v0, input int v1, input int v2,
                      input int v3, input int b, input int exp_score,
                      input int exp_dec, input int hold);
    int   vals[4];
    exp_t e;
    vals = '{v0, v1, v2, v3};
    e.score = 24'(exp_score);
    e.dec   = exp_dec[0];
    q4.push_back(e);
    if4.bias         = 16'(b);
    if4.result_ready = (hold == 0);
    @(posedge clk); #1 if4.start = 1'b1;
    @(posedge clk); #1 if4.start = 1'b0;
    if4.hwf_valid = 1'b1;
    if4.hwf_out   = 16'(vals[0]);
    @(negedge clk) chk({tag, "_busy_after_start"}, if4.busy, 1);
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1 if4.hwf_out = 16'(vals[i]);
    end
    @(posedge clk); #1 if4.hwf_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_sv_cnt_bias"}, if4.sv_cnt, 4);
    chk({tag, "_rv_in_bias"}, if4.result_valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_rv_edge5"}, if4.result_valid, 1);
    chk({tag, "_busy_done"}, if4.busy, 0);
    chk({tag, "_score"}, if4.score, exp_score);
    chk({tag, "_decision"}, if4.decision, exp_dec);
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1 if4.start = (c == 3);
      @(negedge clk);
      chk({tag, "_hold_score"}, if4.score, exp_score);
      chk({tag, "_hold_dec"}, if4.decision, exp_dec);
      chk({tag, "_hold_rv"}, if4.result_valid, 1);
    end
    if4.start = 1'b0;
    if (hold > 0) begin
      @(posedge clk); #1 if4.result_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_rv_pulse_end"}, if4.result_valid, 0);
    chk({tag, "_idle_busy"}, if4.busy, 0);
  endtask

  // 87-SV decision with constant hwf_out; optional 3-cycle stall after the
  // 20th accepted result.
  task automatic run87(input string tag, input logic [15:0] val, input logic [15:0] b,
                       input int exp_score, input int exp_dec, input bit do_stall);
    exp_t e;
    int   n;
    bit   seen;
    e.score = 24'(exp_score);
    e.dec   = exp_dec[0];
    q87.push_back(e);
    if87.bias         = b;
    if87.hwf_out      = val;
    if87.result_ready = 1'b1;
    @(posedge clk); #1 if87.start = 1'b1;
    @(posedge clk); #1 if87.start = 1'b0;
    if87.hwf_valid = 1'b1;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(posedge clk);
      n++;
      #1 if87.stall_MEM = do_stall && (n >= 20) && (n < 23);
      @(negedge clk);
      if (do_stall && n == 20) chk({tag, "_cnt_pre_stall"}, if87.sv_cnt, 20);
      if (do_stall && n == 23) chk({tag, "_cnt_post_stall"}, if87.sv_cnt, 20);
      if (if87.result_valid) seen = 1'b1;
    end
    chk({tag, "_latency"}, n, do_stall ? 91 : 88);
    chk({tag, "_score"}, if87.score, exp_score);
    chk({tag, "_decision"}, if87.decision, exp_dec);
    @(posedge clk); #1 if87.hwf_valid = 1'b0;
    @(negedge clk) chk({tag, "_rv_clear"}, if87.result_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    {if4.stall_MEM, if4.start, if4.hwf_valid, if4.result_ready} = '0;
    if4.hwf_out = '0;
    if4.bias    = '0;
    {if87.stall_MEM, if87.start, if87.hwf_valid, if87.result_ready} = '0;
    if87.hwf_out = '0;
    if87.bias    = '0;
    #23 rst = 1'b0;

    // Reset state, then valids without start are ignored.
    @(negedge clk);
    chk("reset_score", if4.score, 0);
    chk("reset_rv", if4.result_valid, 0);
    chk("reset_busy", if87.busy, 0);
    chk("reset_decision", if87.decision, 0);
    @(posedge clk); #1;
    if4.hwf_valid  = 1'b1;
    if4.hwf_out    = 16'h0010;
    if87.hwf_valid = 1'b1;
    if87.hwf_out   = 16'h0010;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("idle_sv_cnt", if4.sv_cnt, 0);
    chk("idle_rv", if4.result_valid, 0);
    chk("idle_score", if4.score, 0);
    chk("idle_busy", if4.busy, 0);
    chk("idle87_sv_cnt", if87.sv_cnt, 0);
    if4.hwf_valid  = 1'b0;
    if87.hwf_valid = 1'b0;

    // Directed 4-SV decisions.
    run4("neg", 5, -3, 10, 2, -20, -6, 0, 0);
    run4("zero", 10, -10, 0, 0, 0, 0, 1, 0);
    run4("hold", 1, 2, 3, 4, 100, 110, 1, 10);

    // Full 87-SV positive extreme with a mid-ACCUM stall.
    run87("max", 16'h7FFF, 16'h7FFF, 2883496, 1, 1'b1);

    // Asynchronous reset part-way through a decision.
    if87.hwf_out = 16'h0003;
    @(posedge clk); #1 if87.start = 1'b1;
    @(posedge clk); #1 if87.start = 1'b0;
    if87.hwf_valid = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("rst_pre_sv_cnt", if87.sv_cnt, 40);
    rst = 1'b1;
    #1;
    chk("rst_async_sv_cnt", if87.sv_cnt, 0);
    chk("rst_async_score", if87.score, 0);
    chk("rst_async_busy", if87.busy, 0);
    chk("rst_async_dec", if87.decision, 0);
    chk("rst_async_rv", if87.result_valid, 0);
    if87.hwf_valid = 1'b0;
    @(posedge clk); #3 rst = 1'b0;

    // Fresh decision from zero: negative extreme.
    run87("min", 16'h8000, 16'h8000, -2883584, 0, 1'b0);

    repeat (3) @(posedge clk);
    chk("sb4_drained", q4.size(), 0);
    chk("sb87_drained", q87.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
